// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs between the sensor front end and the controller.
// The source side drives raw_* and observes the conditioned signals; the conditioner is the slave.
interface sensor_conditioner_if;
    logic       raw_fd;
    logic       raw_rd;
    logic       raw_w;
    logic       raw_fa;
    logic [6:0] raw_st;
    logic       raw_st_valid;
    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [6:0] ST;
    logic       st_valid;

    modport master (
        output raw_fd, raw_rd, raw_w, raw_fa, raw_st, raw_st_valid,
        input  SFD, SRD, SW, SFA, ST, st_valid
    );

    modport slave (
        input  raw_fd, raw_rd, raw_w, raw_fa, raw_st, raw_st_valid,
        output SFD, SRD, SW, SFA, ST, st_valid
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Purpose: synchronise+debounce four binary sensors, 4-sample moving average of temperature.
// Latency: binary 2+DEBOUNCE_CYCLES edges (SFA rise 2 edges with FIRE_FASTPATH_EN); ST visible 1 cycle after strobe.
// Backpressure: none; every strobe outside reset is accepted, back-to-back included.
module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 1000,
    parameter logic [6:0] RESET_TEMP      = 7'd25
) (
    input  logic                 clk,
    input  logic                 Rst,
    sensor_conditioner_if.slave  sif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef FIRE_FASTPATH_EN
    localparam bit FAST_FA = 1'b1;
`else
    localparam bit FAST_FA = 1'b0;
`endif

    logic [3:0] raw_vec;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] deb;

    assign raw_vec = {sif.raw_fa, sif.raw_w, sif.raw_rd, sif.raw_fd};

    always_ff @(posedge clk) begin
        if (Rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_vec;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_deb
        // Only the fire-alarm channel (bit 3) may take the fast rising path.
        localparam bit FAST = FAST_FA && (g == 3);
        logic [CW-1:0] cnt_q;
        logic          deb_q;

        always_ff @(posedge clk) begin
            if (Rst) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (FAST && s1[g] && !deb_q) begin
                deb_q <= 1'b1;
                cnt_q <= '0;
            end else if (s2[g] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= s2[g];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end

        assign deb[g] = deb_q;
    end

    assign sif.SFD = deb[0];
    assign sif.SRD = deb[1];
    assign sif.SW  = deb[2];
    assign sif.SFA = deb[3];

    // The average covers the incoming sample plus the three newest stored ones,
    // so the oldest window entry never needs a register of its own.
    logic [6:0] w0, w1, w2;
    logic [6:0] st_q;
    logic       st_vld_q;
    logic [8:0] sum;

    assign sum = {2'b00, sif.raw_st} + {2'b00, w0} + {2'b00, w1} + {2'b00, w2};

    always_ff @(posedge clk) begin
        if (Rst) begin
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
            st_q     <= RESET_TEMP;
            st_vld_q <= 1'b0;
        end else if (sif.raw_st_valid) begin
            if (!st_vld_q) begin
                w0       <= sif.raw_st;
                w1       <= sif.raw_st;
                w2       <= sif.raw_st;
                st_q     <= sif.raw_st;
                st_vld_q <= 1'b1;
            end else begin
                w0   <= sif.raw_st;
                w1   <= w0;
                w2   <= w1;
                st_q <= 7'(sum >> 2);
            end
        end
    end

    assign sif.ST       = st_q;
    assign sif.st_valid = st_vld_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: directed scenarios followed by random stimulus,
// checked every cycle against a behavioural model of the debounce and averaging rules.
module tb_sensor_conditioner;

    localparam int D = 4;

`ifdef FIRE_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sensor_conditioner_if sif();

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .RESET_TEMP     (7'd25)
    ) dut (
        .clk(clk),
        .Rst(rst),
        .sif(sif)
    );

    typedef struct packed {
        logic [3:0] bin;
        logic [6:0] st;
        logic       st_vld;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: raw level history per channel and the temperature window.
    bit samp[4][$];
    bit hist[4][$];
    bit m_out[4];
    int m_win[3];
    int m_st;
    bit m_vld;
    bit [3:0] cur_raw;

    function void model_reset();
        for (int c = 0; c < 4; c++) begin
            samp[c].delete();
            hist[c].delete();
            m_out[c] = 1'b0;
        end
        for (int k = 0; k < 3; k++) m_win[k] = 0;
        m_st  = 25;
        m_vld = 1'b0;
    endfunction

    function void model_edge(bit r, bit [3:0] raw, bit stv, int dat);
        exp_t e;
        if (r) begin
            model_reset();
        end else begin
            for (int c = 0; c < 4; c++) begin
                bit s1o, s2o, all_diff;
                int n;
                n   = samp[c].size();
                s1o = (n >= 1) ? samp[c][n-1] : 1'b0;
                s2o = (n >= 2) ? samp[c][n-2] : 1'b0;
                hist[c].push_back(s2o);
                if (FAST && c == 3 && s1o && !m_out[c]) begin
                    m_out[c] = 1'b1;
                end else if (hist[c].size() >= D) begin
                    // Output follows only after D consecutive differing levels since reset.
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (hist[c][hist[c].size()-1-k] == m_out[c]) all_diff = 1'b0;
                    if (all_diff) m_out[c] = ~m_out[c];
                end
                samp[c].push_back(raw[c]);
                if (samp[c].size() > 4)     void'(samp[c].pop_front());
                if (hist[c].size() > D + 2) void'(hist[c].pop_front());
            end
            if (stv) begin
                if (!m_vld) begin
                    for (int k = 0; k < 3; k++) m_win[k] = dat;
                    m_st  = dat;
                    m_vld = 1'b1;
                end else begin
                    m_st     = (dat + m_win[0] + m_win[1] + m_win[2]) / 4;
                    m_win[2] = m_win[1];
                    m_win[1] = m_win[0];
                    m_win[0] = dat;
                end
            end
        end
        e.bin    = {m_out[3], m_out[2], m_out[1], m_out[0]};
        e.st     = 7'(m_st);
        e.st_vld = m_vld;
        exp_q.push_back(e);
    endfunction

    task automatic cycle(input bit r, input bit [3:0] raw, input bit stv, input int dat);
        rst              = r;
        sif.raw_fd       = raw[0];
        sif.raw_rd       = raw[1];
        sif.raw_w        = raw[2];
        sif.raw_fa       = raw[3];
        sif.raw_st_valid = stv;
        sif.raw_st       = stv ? 7'(dat) : 7'(($urandom & 32'h7f));
        @(posedge clk);
        model_edge(r, raw, stv, dat);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, cur_raw, 1'b0, 0);
    endtask

    task automatic strobe(input int dat);
        cycle(1'b0, cur_raw, 1'b1, dat);
    endtask

    // Monitor: one scoreboard entry per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e        = exp_q.pop_front();
            a.bin    = {sif.SFA, sif.SW, sif.SRD, sif.SFD};
            a.st     = sif.ST;
            a.st_vld = sif.st_valid;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got bin=%b ST=%0d st_valid=%b required bin=%b ST=%0d st_valid=%b",
                         $time, a.bin, a.st, a.st_vld, e.bin, e.st, e.st_vld);
            end
        end
    end

    initial begin
        model_reset();
        cur_raw = 4'b0000;

        cycle(1'b1, 4'b0000, 1'b1, 99);
        cycle(1'b1, 4'b0000, 1'b0, 0);
        idle(3);

        // Clean step on front door.
        cur_raw[0] = 1'b1;
        idle(10);

        // Window glitches of 3 and 5 cycles.
        cur_raw[2] = 1'b1; idle(3);
        cur_raw[2] = 1'b0; idle(8);
        cur_raw[2] = 1'b1; idle(5);
        cur_raw[2] = 1'b0; idle(10);

        // Averaging, back-to-back strobes.
        strobe(40); strobe(40); strobe(44); strobe(48); strobe(52); strobe(127);
        idle(3);

        // Reset mid-debounce on rear door, then re-prime.
        cur_raw[1] = 1'b1; idle(4);
        cycle(1'b1, cur_raw, 1'b1, 77);
        idle(3);
        strobe(30);
        idle(8);

        // Fire alarm rise and release.
        cur_raw[3] = 1'b1; idle(10);
        cur_raw[3] = 1'b0; idle(10);

        // Random section: short and long pulses, random strobes, rare resets.
        for (int i = 0; i < 3000; i++) begin
            bit r, stv;
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) cur_raw[c] = ~cur_raw[c];
            r   = ($urandom_range(0, 299) == 0);
            stv = ($urandom_range(0, 2) == 0);
            cycle(r, cur_raw, stv, int'($urandom_range(0, 127)));
        end

        idle(4);
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
